// File: rtl/reg_port_arb.sv
// ============================================================================
// reg_port_arb : core/debug arbiter and sequencer for the register file ports.
// Optional build macro: REG_ARB_BYPASS_EN (same-cycle write-to-read bypass).
// Revision: 1.0
// ============================================================================
`default_nettype none

module reg_port_arb #(
  parameter int D_WIDTH    = 32,
  parameter int STARVE_LIM = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_rd_req,
  input  logic [4:0]         core_rs1,
  input  logic [4:0]         core_rs2,
  output logic               core_rd_gnt,
  output logic               core_rd_vld,
  output logic [D_WIDTH-1:0] core_rs1_dat,
  output logic [D_WIDTH-1:0] core_rs2_dat,
  input  logic               core_wr_req,
  input  logic [4:0]         core_wr_rd,
  input  logic [D_WIDTH-1:0] core_wr_dat,
  output logic               core_wr_gnt,
  input  logic               dbg_rd_req,
  input  logic [4:0]         dbg_rs,
  output logic               dbg_rd_gnt,
  output logic               dbg_rd_vld,
  output logic [D_WIDTH-1:0] dbg_rd_dat,
  input  logic               dbg_wr_req,
  input  logic [4:0]         dbg_wr_rd,
  input  logic [D_WIDTH-1:0] dbg_wr_dat,
  output logic               dbg_wr_gnt,
  output logic               regLd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2,
  output logic               regStr,
  output logic [4:0]         rd,
  output logic [D_WIDTH-1:0] WBDat,
  input  logic [D_WIDTH-1:0] rs1Out,
  input  logic [D_WIDTH-1:0] rs2Out
);

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIM);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DBG  = 2'd2
  } own_t;

  own_t       r_own;
  logic [3:0] r_rd_cnt;
  logic [3:0] r_wr_cnt;

  logic               w_wr_dbg_win;
  logic               w_rd_dbg_win;
  logic               w_rd_any;
  logic [4:0]         w_src1;
  logic [4:0]         w_src2;
  logic               w_hit1;
  logic               w_hit2;
  logic               w_stall;
  logic               w_rd_go;
  logic [D_WIDTH-1:0] w_d1;
  logic [D_WIDTH-1:0] w_d2;

  // Write channel
  assign w_wr_dbg_win = dbg_wr_req && (!core_wr_req || (r_wr_cnt == c_starve_lim));
  assign dbg_wr_gnt   = w_wr_dbg_win;
  assign core_wr_gnt  = core_wr_req && !w_wr_dbg_win;
  assign regStr       = core_wr_gnt || dbg_wr_gnt;
  assign rd           = dbg_wr_gnt ? dbg_wr_rd  : (core_wr_gnt ? core_wr_rd  : 5'd0);
  assign WBDat        = dbg_wr_gnt ? dbg_wr_dat : (core_wr_gnt ? core_wr_dat : '0);

  // Read channel: pick the owner first, then check its sources against the write
  assign w_rd_dbg_win = dbg_rd_req && (!core_rd_req || (r_rd_cnt == c_starve_lim));
  assign w_rd_any     = core_rd_req || dbg_rd_req;
  assign w_src1       = w_rd_dbg_win ? dbg_rs : core_rs1;
  assign w_src2       = w_rd_dbg_win ? 5'd0   : core_rs2;
  assign w_hit1       = regStr && (rd != 5'd0) && (w_src1 == rd);
  assign w_hit2       = regStr && (rd != 5'd0) && (w_src2 == rd);

`ifdef REG_ARB_BYPASS_EN
  assign w_stall = 1'b0;
`else
  assign w_stall = w_hit1 || w_hit2;
`endif

  assign w_rd_go     = w_rd_any && !w_stall;
  assign dbg_rd_gnt  = w_rd_go && w_rd_dbg_win;
  assign core_rd_gnt = w_rd_go && !w_rd_dbg_win;
  assign regLd       = w_rd_go;
  assign rs1         = w_rd_go ? w_src1 : 5'd0;
  assign rs2         = w_rd_go ? w_src2 : 5'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_own    <= OWN_NONE;
      r_rd_cnt <= 4'd0;
      r_wr_cnt <= 4'd0;
    end else begin
      r_own <= dbg_rd_gnt ? OWN_DBG : (core_rd_gnt ? OWN_CORE : OWN_NONE);
      // A hazard stall is not a lost arbitration, so the counter holds
      if (!dbg_rd_req || dbg_rd_gnt)
        r_rd_cnt <= 4'd0;
      else if (!w_stall && (r_rd_cnt != c_starve_lim))
        r_rd_cnt <= r_rd_cnt + 4'd1;
      if (!dbg_wr_req || dbg_wr_gnt)
        r_wr_cnt <= 4'd0;
      else if (r_wr_cnt != c_starve_lim)
        r_wr_cnt <= r_wr_cnt + 4'd1;
    end
  end

`ifdef REG_ARB_BYPASS_EN
  logic               r_byp1;
  logic               r_byp2;
  logic [D_WIDTH-1:0] r_byp_dat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byp1    <= 1'b0;
      r_byp2    <= 1'b0;
      r_byp_dat <= '0;
    end else begin
      r_byp1    <= w_rd_go && w_hit1;
      r_byp2    <= w_rd_go && w_hit2;
      r_byp_dat <= WBDat;
    end
  end

  assign w_d1 = r_byp1 ? r_byp_dat : rs1Out;
  assign w_d2 = r_byp2 ? r_byp_dat : rs2Out;
`else
  assign w_d1 = rs1Out;
  assign w_d2 = rs2Out;
`endif

  assign core_rd_vld  = (r_own == OWN_CORE);
  assign dbg_rd_vld   = (r_own == OWN_DBG);
  assign core_rs1_dat = core_rd_vld ? w_d1 : '0;
  assign core_rs2_dat = core_rd_vld ? w_d2 : '0;
  assign dbg_rd_dat   = dbg_rd_vld  ? w_d1 : '0;

endmodule

`default_nettype wire

// File: doc/reg_port_arb.md
# reg_port_arb

Two-requester arbiter and sequencer for the 32-entry register file's read pair and write port. Shares the file between the core pipeline (primary) and the debug module (secondary), drives `regLd`/`regStr`/`rs1`/`rs2`/`rd`/`WBDat`, and routes the registered read data back to the owner one cycle later. Resolves same-cycle read-after-write hazards and enforces bounded debug starvation. Sits between decode/writeback, the debug unit, and the register file.

## Interface
- `D_WIDTH`, 32, register data width.
- `STARVE_LIM`, 4, consecutive debug-losing cycles before debug is forced a grant (1..15).
- `clk`  in  1  clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `core_rd_req` / `core_rs1` / `core_rs2`  in  1/5/5  core read request and source indices.
- `core_rd_gnt`  out  1  core read accepted this cycle.
- `core_rd_vld`  out  1  core read data valid (cycle after grant).
- `core_rs1_dat` / `core_rs2_dat`  out  D_WIDTH  core read data.
- `core_wr_req` / `core_wr_rd` / `core_wr_dat`  in  1/5/D_WIDTH  core write request.
- `core_wr_gnt`  out  1  core write accepted this cycle.
- `dbg_rd_req` / `dbg_rs`  in  1/5  debug single-register read.
- `dbg_rd_gnt` / `dbg_rd_vld`  out  1/1  debug read grant / data valid.
- `dbg_rd_dat`  out  D_WIDTH  debug read data.
- `dbg_wr_req` / `dbg_wr_rd` / `dbg_wr_dat`  in  1/5/D_WIDTH  debug write request.
- `dbg_wr_gnt`  out  1  debug write accepted.
- `regLd` / `rs1` / `rs2`  out  1/5/5  register-file read strobe and indices.
- `regStr` / `rd` / `WBDat`  out  1/5/D_WIDTH  register-file write strobe, index, data.
- `rs1Out` / `rs2Out`  in  D_WIDTH  register-file registered read data.

## Operation
- Read and write channels arbitrate independently each cycle; grants and file strobes are combinational from requests plus state.
- Requests are level-held until the matching `*_gnt`; grant is a single-cycle acceptance.
- Priority per channel: core wins unless that channel's starvation counter equals `STARVE_LIM`, then debug wins for one cycle and the counter clears.
- Starvation counter (per channel, 4 bits): increments when debug requests and loses; clears on debug grant or debug request low; saturates at `STARVE_LIM`.
- Debug read drives `rs1 = dbg_rs`, `rs2 = 0`; returns `rs1Out`.
- Read owner register: {NONE, CORE, DBG}, loaded with the granted owner, else NONE. Next cycle, `core_rd_vld` or `dbg_rd_vld` is asserted for exactly that owner; data buses pass `rs1Out`/`rs2Out` (zero when not valid).
- Writes to index 0 are granted and strobed; the file discards them. Index 0 never participates in hazard checks.
- Hazard: a granted read whose nonzero source equals the granted write's `rd` in the same cycle (see Configuration).
- Idle: all strobes, grants, and valids low; indices and `WBDat` zero.

## Timing
- Reset: all grants, valids, `regLd`, `regStr` = 0; indices, `WBDat`, and read data = 0; owner = NONE; counters = 0. Reset mid-transaction drops any pending return (no valid after reset release).
- Read latency: grant in cycle T → valid in T+1. Back-to-back reads are sustained at one per cycle.
- Write: grant in T → file updated at the end of T; a read granted in T+1 sees the new value.
- Simultaneous core and debug on both channels: core gets both unless a counter is at its limit.

## Configuration
- `REG_ARB_BYPASS_EN` defined: on a hazard, the read is still granted in T. The write data and match flags are registered, and in T+1 the matching source's returned data is replaced with that write data. Full throughput.
- Not defined: on a hazard, the read grant is withheld in T while the write proceeds. The read is granted in T+1 (one-cycle stall) and the starvation counter does not increment for that stall.

## Test plan
- Reset asserted mid-read (grant in T, `rst` in T) → no `core_rd_vld` after release; all outputs 0.
- Core writes x5=0xDEADBEEF in T0, core reads rs1=5 in T1 → `core_rd_vld` in T2 with `core_rs1_dat`=0xDEADBEEF.
- Same-cycle core read rs1=7 and debug write x7=0x12345678 (core write idle) → with bypass: read granted T, data 0x12345678 in T+1. Without bypass: `core_rd_gnt` low in T, granted T+1, data 0x12345678 in T+2.
- Core and debug read requests held continuously, `STARVE_LIM`=4 → debug granted on the 5th cycle, then every 5th cycle; `dbg_rd_vld` follows each debug grant by 1 cycle.
- Debug write to x0 with 0xFFFFFFFF → `dbg_wr_gnt`=1 and `regStr`=1 with `rd`=0; a later read of x0 returns 0; no hazard stall against a simultaneous read of x0.
- Alternating core reads rs1=1/rs2=2 every cycle for 8 cycles → 8 consecutive `core_rd_vld` pulses, each with the correct data.
